cpu_bus_arbiter: RTL

- Sits directly downstream of the CPU core. Merges its instruction bus (read-only, from ICache) and data bus (read/write, from DCache) onto one shared memory-side bus feeding the interconnect/RAM.
- Arbitration is fair: if both masters are pending, the one not serviced last wins.
- Grant is registered and held for a full waitrequest handshake.
- A watchdog releases a master stuck behind an unresponsive slave.

---
 rtl/cpu_bus_pkg.sv | 22 ++
 rtl/bus_timeout_counter.sv | 45 ++++
 rtl/cpu_bus_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus arbiter.
// Holds the arbiter state encoding, master identifiers and default watchdog sizing.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGrantI = 2'b01,
    StGrantD = 2'b10
  } arb_state_e;

  localparam logic MasterI = 1'b0;
  localparam logic MasterD = 1'b1;

  localparam int unsigned DefaultTimeoutCycles = 255;
  localparam int unsigned DefaultTimeoutWidth  = 8;

  // Grant state that services the given master.
  function automatic arb_state_e grant_state(input logic master);
    return (master == MasterD) ? StGrantD : StGrantI;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Watchdog counter for a granted bus transaction.
// Counts enabled cycles and raises expire_o while the count equals the limit.
// A limit of zero disables the watchdog entirely.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   clear_i    : return the count to zero (has priority over count_en_i)
//   count_en_i : advance the count by one this cycle
//   limit_i    : expiry threshold, 0 = disabled
//   expire_o   : high in the cycle the count has reached limit_i
module bus_timeout_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             count_en_i,
  input  logic [Width-1:0] limit_i,
  output logic             expire_o
);

  logic [Width-1:0] count_q, count_d;
  logic             enabled;

  assign enabled  = (limit_i != '0);
  assign expire_o = enabled && (count_q == limit_i);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i && enabled && !expire_o) begin
      // Never step past the limit; the owner clears us on expiry.
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Two-master arbiter merging the CPU instruction bus (read-only) and data bus
// (read/write) onto one shared memory-side bus.
// Ties go to the master that was not serviced last; the grant is registered and
// held until the granted request completes, drops, or the watchdog forces it out.
//   i_Clk / i_Reset         : clock, synchronous active-high reset
//   i_IBus_* / o_IBus_*     : instruction master (read-only, word addressed)
//   i_DBus_* / o_DBus_*     : data master (read/write with byte enables)
//   o_Mem_* / i_Mem_*       : shared slave-side bus
//   o_Timeout               : sticky flag, set when the watchdog forced a completion
module cpu_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned P_TIMEOUT_CYCLES = DefaultTimeoutCycles,
  parameter int unsigned P_TIMEOUT_WIDTH  = DefaultTimeoutWidth
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  // Instruction master
  input  logic [29:0] i_IBus_Address,
  input  logic        i_IBus_Read,
  output logic [31:0] o_IBus_ReadData,
  output logic        o_IBus_WaitReq,
  // Data master
  input  logic [29:0] i_DBus_Address,
  input  logic [3:0]  i_DBus_ByteEn,
  input  logic        i_DBus_Read,
  input  logic        i_DBus_Write,
  input  logic [31:0] i_DBus_WriteData,
  output logic [31:0] o_DBus_ReadData,
  output logic        o_DBus_WaitRequest,
  // Shared memory bus
  output logic [29:0] o_Mem_Address,
  output logic [3:0]  o_Mem_ByteEn,
  output logic        o_Mem_Read,
  output logic        o_Mem_Write,
  output logic [31:0] o_Mem_WriteData,
  input  logic [31:0] i_Mem_ReadData,
  input  logic        i_Mem_WaitRequest,
  // Status
  output logic        o_Timeout
);

  localparam logic [P_TIMEOUT_WIDTH-1:0] TimeoutLimit = P_TIMEOUT_WIDTH'(P_TIMEOUT_CYCLES);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       timeout_q, timeout_d;

  logic i_req, d_req;
  logic own_req;     // request of the currently granted master
  logic expire;      // watchdog has reached its limit
  logic forced;      // watchdog forced completion this cycle
  logic done;        // granted transfer completes this cycle
  logic cnt_clear, cnt_en;

  assign i_req = i_IBus_Read;
  assign d_req = i_DBus_Read | i_DBus_Write;

  always_comb begin
    case (state_q)
      StGrantI: own_req = i_req;
      StGrantD: own_req = d_req;
      default:  own_req = 1'b0;
    endcase
  end

  // Expiry only matters while the master still holds its request; a drop in the
  // same cycle is treated as a plain drop.
  assign forced = expire & own_req;
  assign done   = own_req & (~i_Mem_WaitRequest | forced);

  assign cnt_clear = (state_q == StIdle) | done | ~own_req;
  assign cnt_en    = own_req & i_Mem_WaitRequest & ~forced;

  bus_timeout_counter #(
    .Width (P_TIMEOUT_WIDTH)
  ) u_timeout (
    .clk_i      (i_Clk),
    .rst_i      (i_Reset),
    .clear_i    (cnt_clear),
    .count_en_i (cnt_en),
    .limit_i    (TimeoutLimit),
    .expire_o   (expire)
  );

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    timeout_d    = timeout_q | forced;
    case (state_q)
      StIdle: begin
        if (i_req && d_req) begin
          state_d = grant_state(~last_grant_q);
        end else if (d_req) begin
          state_d = StGrantD;
        end else if (i_req) begin
          state_d = StGrantI;
        end
      end
      StGrantI: begin
        if (done) begin
          last_grant_d = MasterI;
          // Hand straight over to a waiting data master, no idle gap.
          state_d      = d_req ? StGrantD : StIdle;
        end else if (!i_req) begin
          state_d = StIdle;
        end
      end
      StGrantD: begin
        if (done) begin
          last_grant_d = MasterD;
          state_d      = i_req ? StGrantI : StIdle;
        end else if (!d_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= StIdle;
      last_grant_q <= MasterI;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      timeout_q    <= timeout_d;
    end
  end

  // Routing muxes: the granted master drives the shared bus combinationally.
  always_comb begin
    o_Mem_Address      = '0;
    o_Mem_ByteEn       = '0;
    o_Mem_Read         = 1'b0;
    o_Mem_Write        = 1'b0;
    o_Mem_WriteData    = '0;
    o_IBus_WaitReq     = 1'b1;
    o_IBus_ReadData    = '0;
    o_DBus_WaitRequest = 1'b1;
    o_DBus_ReadData    = '0;
    case (state_q)
      StGrantI: begin
        o_Mem_Read      = i_req & ~forced;
        o_Mem_Address   = i_req ? i_IBus_Address : '0;
        o_Mem_ByteEn    = i_req ? 4'hF : 4'h0;
        o_IBus_WaitReq  = i_Mem_WaitRequest & ~forced;
        o_IBus_ReadData = forced ? 32'h0 : i_Mem_ReadData;
      end
      StGrantD: begin
        // Read together with write is illegal; the write wins.
        o_Mem_Write        = i_DBus_Write & ~forced;
        o_Mem_Read         = i_DBus_Read & ~i_DBus_Write & ~forced;
        o_Mem_Address      = d_req ? i_DBus_Address : '0;
        o_Mem_ByteEn       = d_req ? i_DBus_ByteEn : 4'h0;
        o_Mem_WriteData    = d_req ? i_DBus_WriteData : '0;
        o_DBus_WaitRequest = i_Mem_WaitRequest & ~forced;
        o_DBus_ReadData    = forced ? 32'h0 : i_Mem_ReadData;
      end
      default: ;
    endcase
  end

  assign o_Timeout = timeout_q;

endmodule
